tx_char_replace_gen: RTL and testbench
======================================

# tx_char_replace_gen

Parametrised JESD204B transmit character-replacement stage, placed per lane between the transport/scrambler output and the 8b/10b encoder. It tracks frame and multiframe boundaries internally from the runtime `F` and `K` settings. It replaces frame-end and multiframe-end octets with /F/ (K28.7) or /A/ (K28.3) according to the JESD204B rules for both the non-scrambled and scrambled link modes. It emits boundary flags aligned with the output data for downstream blocks.

## Interface
- `W`, 4, octets per clock beat; legal values 4 and 8.
- `CLK`  in  1  link clock; all logic is on the rising edge.
- `RST_n`  in  1  synchronous, active-low reset.
- `EN`  in  1  data phase active. The first beat with `EN` high carries octet 0 of multiframe 0.
- `F`  in  8  octets per frame minus 1.
- `K`  in  5  frames per multiframe minus 1.
- `SCR`  in  1  scrambling enabled on the link (selects the replacement rule).
- `DI_K`  in  W  control-character flag per input octet.
- `DI`  in  W×8  input octets; lane 0 is the earliest in time.
- `DO_K`  out  W  control-character flag per output octet.
- `DO`  out  W×8  output octets.
- `FE_O`  out  W  frame-end flag per output octet.
- `ME_O`  out  W  multiframe-end flag per output octet.

## Operation
- Position tracking:
  - Registers `oct_base` (8 b) and `frm_base` (5 b) give the position of lane 0 of the current beat.
  - Per lane: o_{i+1} = (o_i == F) ? 0 : o_i+1.
  - The frame counter advances on each frame end and wraps from `K` to 0.
  - Octet i is a frame end when o_i == F. It is a multiframe end when it is a frame end and its frame index == K.
- While `EN` is low:
  - Both bases are held at 0 and the history (`last_fe`, `last_valid`, `last_repl`) is cleared.
  - Data passes through unmodified.
  - `FE_O` and `ME_O` are 0.
- History:
  - `last_fe` holds the original (pre-replacement) value of the most recent frame-end octet.
  - `last_valid` is set once any frame end has been seen since `EN` rose.
  - `last_repl` records whether that octet was replaced (/F/ or /A/).
  - Within a beat the history chains lane by lane, so F=0 works with every octet as a frame end.
- Non-scrambled rule (`SCR`=0, or macro absent), applied at a frame-end octet with DI_K=0 and `last_valid` set:
  - Multiframe end and DI == last_fe: output /A/ (0x7C, K=1).
  - Otherwise, non-multiframe frame end, DI == last_fe and `last_repl` = 0: output /F/ (0xFC, K=1).
  - Otherwise the octet passes unchanged.
- Scrambled rule (`SCR`=1, macro present), with no history dependency:
  - Frame-end octet, not a multiframe end, equal to 0xFC: output /F/.
  - Multiframe-end octet equal to 0x7C: output /A/.
  - All other octets pass, including 0xFC at a multiframe end.
- An octet with DI_K=1 is never replaced, passes with its K flag, and updates `last_fe` with `last_repl`=0.
- `F` and `K` are stable while `EN` is high. (F+1)·(K+1) is a multiple of `W`; behaviour otherwise is undefined.

## Timing
- Fixed latency of 2 cycles from `DI`/`DI_K` to `DO`/`DO_K`/`FE_O`/`ME_O`, in every mode.
- Stage 1 registers the data, positions and equality flags. Stage 2 resolves the chain and registers the outputs.
- `EN` is pipelined with the data. Deasserting `EN` affects outputs 2 cycles later, and re-asserting it restarts at octet 0 with empty history.
- Reset: on the first rising edge with `RST_n` low, `DO`, `DO_K`, `FE_O`, `ME_O`, both counters and all history go to 0. A reset mid-multiframe discards the pipeline contents.

## Configuration
- Macro `JESD_TX_CHAR_REPLACE_SCR_EN`:
  - Defined: the scrambled rule is compiled in and selected by `SCR`.
  - Undefined: the `SCR` port is present but ignored, and only the non-scrambled rule exists.

## Test plan
- W=4, F=0, K=3, SCR=0, every octet 0x55 from the first `EN` beat:
  - Beat 0 output, lanes 0..3, is 0x55, /F/, 0x55, /A/.
  - Every later beat outputs 0x55, /F/, 0x55, /A/.
  - `ME_O` = 4'b1000 and `FE_O` = 4'b1111.
- W=4, F=1, K=1, SCR=0, constant 0xAA:
  - Lane 1 passes (0xAA) on beat 0 because there is no history, and passes on later beats because the previous frame end was replaced.
  - Lane 3 is /A/ on every beat.
  - `FE_O` = 4'b1010.
- Macro defined, SCR=1, W=4, F=3, K=1:
  - Beat 0 lane 3 = 0xFC gives /F/.
  - Beat 1 lane 3 = 0x7C gives /A/.
  - Beat 3 lane 3 = 0xFC at a multiframe end passes as 0xFC with K=0.
  - Lane 1 = 0xFC passes.
- `EN` drops for 3 cycles mid-multiframe, then rises with constant data:
  - Outputs are unmodified while `EN` is low.
  - After `EN` rises the first frame end is not replaced and the flags restart at octet 0.
- `RST_n` low for one cycle during traffic: the next outputs are all 0. The first beat after `EN` rises again produces its output after 2 cycles.
- F=0, SCR=0, DI_K=1 on lane 2 with value 0xBC: `DO` lane 2 is 0xBC with K=1, and lane 3 (equal data) may receive /F/.

Source files
------------

// File: rtl/tx_char_replace_gen.sv
// JESD204B transmit character replacement: tracks frame/multiframe position and swaps frame-end
// octets for /F/ (K28.7) or /A/ (K28.3). Optional macro JESD_TX_CHAR_REPLACE_SCR_EN adds the scrambled rule.

module tx_char_replace_gen #(
    parameter int W = 4
) (
    input  logic           CLK,
    input  logic           RST_n,
    input  logic           EN,
    input  logic [7:0]     F,
    input  logic [4:0]     K,
    input  logic           SCR,
    input  logic [W-1:0]   DI_K,
    input  logic [W*8-1:0] DI,
    output logic [W-1:0]   DO_K,
    output logic [W*8-1:0] DO,
    output logic [W-1:0]   FE_O,
    output logic [W-1:0]   ME_O
);

    localparam logic [7:0] CHAR_F = 8'hFC;
    localparam logic [7:0] CHAR_A = 8'h7C;

    logic [7:0]     octBase_q, octBase_d;
    logic [4:0]     frmBase_q, frmBase_d;
    logic [W-1:0]   feLane, meLane, eqF, eqA;

    logic           en1_q;
    logic [W*8-1:0] di1_q;
    logic [W-1:0]   dik1_q, fe1_q, me1_q, eqF1_q, eqA1_q;

    logic [W*8-1:0] doData_q, doData_d;
    logic [W-1:0]   doK_q, doK_d, feOut_q, feOut_d, meOut_q, meOut_d;
    logic [7:0]     lastFe_q, lastFe_d;
    logic           lastValid_q, lastValid_d, lastRepl_q, lastRepl_d;

    logic           scrMode;

`ifdef JESD_TX_CHAR_REPLACE_SCR_EN
    logic scr1_q;

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            scr1_q <= 1'b0;
        end else begin
            scr1_q <= SCR;
        end
    end

    assign scrMode = scr1_q;
`else
    logic unusedScr;
    assign unusedScr = SCR;
    assign scrMode   = 1'b0;
`endif

    // Walk lane positions forward from the beat base; flags are masked while the link is idle.
    always_comb begin : stage1Positions
        logic [7:0] oct;
        logic [4:0] frm;
        oct    = octBase_q;
        frm    = frmBase_q;
        feLane = '0;
        meLane = '0;
        eqF    = '0;
        eqA    = '0;
        for (int i = 0; i < W; i++) begin
            eqF[i] = (DI[i*8 +: 8] == CHAR_F);
            eqA[i] = (DI[i*8 +: 8] == CHAR_A);
            if (oct == F) begin
                feLane[i] = EN;
                meLane[i] = EN && (frm == K);
                oct       = '0;
                frm       = (frm == K) ? '0 : frm + 5'd1;
            end else begin
                oct = oct + 8'd1;
            end
        end
        octBase_d = EN ? oct : '0;
        frmBase_d = EN ? frm : '0;
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            octBase_q <= '0;
            frmBase_q <= '0;
            en1_q     <= 1'b0;
            di1_q     <= '0;
            dik1_q    <= '0;
            fe1_q     <= '0;
            me1_q     <= '0;
            eqF1_q    <= '0;
            eqA1_q    <= '0;
        end else begin
            octBase_q <= octBase_d;
            frmBase_q <= frmBase_d;
            en1_q     <= EN;
            di1_q     <= DI;
            dik1_q    <= DI_K;
            fe1_q     <= feLane;
            me1_q     <= meLane;
            eqF1_q    <= eqF;
            eqA1_q    <= eqA;
        end
    end

    // History chains lane by lane so several frame ends in one beat see each other.
    always_comb begin : stage2Replace
        logic [7:0] hFe;
        logic       hValid;
        logic       hRepl;
        logic [7:0] octI;
        logic       isRepl;
        logic       isA;
        hFe      = lastFe_q;
        hValid   = lastValid_q;
        hRepl    = lastRepl_q;
        octI     = '0;
        isRepl   = 1'b0;
        isA      = 1'b0;
        doData_d = di1_q;
        doK_d    = dik1_q;
        feOut_d  = fe1_q;
        meOut_d  = me1_q;
        for (int i = 0; i < W; i++) begin
            octI   = di1_q[i*8 +: 8];
            isRepl = 1'b0;
            isA    = 1'b0;
            if (fe1_q[i]) begin
                if (!dik1_q[i]) begin
                    if (scrMode) begin
                        if (!me1_q[i] && eqF1_q[i]) begin
                            isRepl = 1'b1;
                        end else if (me1_q[i] && eqA1_q[i]) begin
                            isRepl = 1'b1;
                            isA    = 1'b1;
                        end
                    end else if (hValid && (octI == hFe)) begin
                        if (me1_q[i]) begin
                            isRepl = 1'b1;
                            isA    = 1'b1;
                        end else if (!hRepl) begin
                            isRepl = 1'b1;
                        end
                    end
                end
                if (isRepl) begin
                    doData_d[i*8 +: 8] = isA ? CHAR_A : CHAR_F;
                    doK_d[i]           = 1'b1;
                end
                hFe    = octI;
                hValid = 1'b1;
                hRepl  = isRepl;
            end
        end
        lastFe_d    = en1_q ? hFe    : '0;
        lastValid_d = en1_q ? hValid : 1'b0;
        lastRepl_d  = en1_q ? hRepl  : 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            doData_q    <= '0;
            doK_q       <= '0;
            feOut_q     <= '0;
            meOut_q     <= '0;
            lastFe_q    <= '0;
            lastValid_q <= 1'b0;
            lastRepl_q  <= 1'b0;
        end else begin
            doData_q    <= doData_d;
            doK_q       <= doK_d;
            feOut_q     <= feOut_d;
            meOut_q     <= meOut_d;
            lastFe_q    <= lastFe_d;
            lastValid_q <= lastValid_d;
            lastRepl_q  <= lastRepl_d;
        end
    end

    assign DO   = doData_q;
    assign DO_K = doK_q;
    assign FE_O = feOut_q;
    assign ME_O = meOut_q;

endmodule

// File: tb/tb_tx_char_replace_gen.sv
// Bench for tx_char_replace_gen (W=4): directed vector tables, hand-written EN/reset sequences,
// and randomized traffic checked against an index-arithmetic reference model.

module tb_tx_char_replace_gen;

    logic        CLK;
    logic        RST_n;
    logic        EN;
    logic [7:0]  F;
    logic [4:0]  K;
    logic        SCR;
    logic [3:0]  DI_K;
    logic [31:0] DI;
    logic [3:0]  DO_K;
    logic [31:0] DO;
    logic [3:0]  FE_O;
    logic [3:0]  ME_O;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic [3:0]  fe;
        logic [3:0]  me;
    } outRec_t;

    typedef struct {
        logic        en;
        logic [31:0] di;
        logic [3:0]  dik;
        outRec_t     exp;
    } vec_t;

    int      errors;
    int      checks;
    outRec_t pipe0;
    outRec_t expOut;
    int      mN;
    logic [7:0] mLastFe;
    logic    mLastValid;
    logic    mLastRepl;
    vec_t    vecs[$];

    tx_char_replace_gen #(.W(4)) dut (
        .CLK  (CLK),
        .RST_n(RST_n),
        .EN   (EN),
        .F    (F),
        .K    (K),
        .SCR  (SCR),
        .DI_K (DI_K),
        .DI   (DI),
        .DO_K (DO_K),
        .DO   (DO),
        .FE_O (FE_O),
        .ME_O (ME_O)
    );

    always #5 CLK = ~CLK;

    function automatic outRec_t mkRec(input logic [31:0] d, input logic [3:0] k,
                                      input logic [3:0] fe, input logic [3:0] me);
        outRec_t r;
        r.d = d; r.k = k; r.fe = fe; r.me = me;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkRecord(input string name, input outRec_t e);
        checkOutput({name, " DO"},   DO,          e.d);
        checkOutput({name, " DO_K"}, {28'h0, DO_K}, {28'h0, e.k});
        checkOutput({name, " FE_O"}, {28'h0, FE_O}, {28'h0, e.fe});
        checkOutput({name, " ME_O"}, {28'h0, ME_O}, {28'h0, e.me});
    endtask

    // Reference: absolute octet index n since EN rose; position = n mod (F+1), frame = n div (F+1) mod (K+1).
    task automatic modelStep(input logic en, input logic rstn, input logic [31:0] di,
                             input logic [3:0] dik, output outRec_t r);
        logic scrRule;
`ifdef JESD_TX_CHAR_REPLACE_SCR_EN
        scrRule = SCR;
`else
        scrRule = 1'b0;
`endif
        r = '0;
        if (!rstn || !en) begin
            mN = 0; mLastFe = 8'h0; mLastValid = 1'b0; mLastRepl = 1'b0;
            if (rstn) begin
                r.d = di;
                r.k = dik;
            end
        end else begin
            r.d = di;
            r.k = dik;
            for (int i = 0; i < 4; i++) begin
                int idx;
                int pos;
                int frame;
                int repl;
                logic [7:0] oct;
                idx   = mN + i;
                pos   = idx % (int'(F) + 1);
                frame = (idx / (int'(F) + 1)) % (int'(K) + 1);
                oct   = di[i*8 +: 8];
                repl  = 0;
                if (pos == int'(F)) begin
                    r.fe[i] = 1'b1;
                    r.me[i] = (frame == int'(K));
                    if (!dik[i]) begin
                        if (scrRule) begin
                            if (!r.me[i] && oct == 8'hFC) repl = 1;
                            if (r.me[i] && oct == 8'h7C)  repl = 2;
                        end else if (mLastValid && oct == mLastFe) begin
                            if (r.me[i])         repl = 2;
                            else if (!mLastRepl) repl = 1;
                        end
                    end
                    if (repl == 1) begin
                        r.d[i*8 +: 8] = 8'hFC;
                        r.k[i] = 1'b1;
                    end else if (repl == 2) begin
                        r.d[i*8 +: 8] = 8'h7C;
                        r.k[i] = 1'b1;
                    end
                    mLastFe    = oct;
                    mLastValid = 1'b1;
                    mLastRepl  = (repl != 0);
                end
            end
            mN = mN + 4;
        end
    endtask

    // Drive one beat at the falling edge, clock it, then compare outputs against the model.
    task automatic applyStimulus(input logic en, input logic [31:0] di, input logic [3:0] dik, input logic rstn);
        outRec_t m;
        RST_n = rstn;
        EN    = en;
        DI    = di;
        DI_K  = dik;
        modelStep(en, rstn, di, dik, m);
        @(posedge CLK);
        if (rstn) begin
            expOut = pipe0;
            pipe0  = m;
        end else begin
            expOut = '0;
            pipe0  = '0;
        end
        @(negedge CLK);
        checkRecord("model", expOut);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 32'h0, 4'h0, 1'b1);
    endtask

    task automatic addVec(input logic en, input logic [31:0] di, input logic [3:0] dik, input outRec_t e);
        vec_t v;
        v.en = en; v.di = di; v.dik = dik; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic runVectors(input string name);
        for (int i = 0; i <= vecs.size(); i++) begin
            int j;
            j = (i < vecs.size()) ? i : vecs.size() - 1;
            applyStimulus(vecs[j].en, vecs[j].di, vecs[j].dik, 1'b1);
            if (i > 0) checkRecord($sformatf("%s beat %0d", name, i - 1), vecs[i-1].exp);
        end
        vecs.delete();
    endtask

    initial begin
        errors = 0; checks = 0;
        CLK = 1'b0; RST_n = 1'b0; EN = 1'b0; SCR = 1'b0; F = 8'd0; K = 5'd3;
        DI = 32'h0; DI_K = 4'h0;
        pipe0 = '0; expOut = '0;
        mN = 0; mLastFe = 8'h0; mLastValid = 1'b0; mLastRepl = 1'b0;
        @(negedge CLK);
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b0);
        checkRecord("reset", mkRec(32'h0, 4'h0, 4'h0, 4'h0));

        F = 8'd0; K = 5'd3; SCR = 1'b0;
        idle(2);
        repeat (4) addVec(1'b1, 32'h55555555, 4'h0, mkRec(32'h7C55FC55, 4'b1010, 4'b1111, 4'b1000));
        runVectors("f0k3");
        idle(3);

        F = 8'd1; K = 5'd1;
        idle(1);
        repeat (3) addVec(1'b1, 32'hAAAAAAAA, 4'h0, mkRec(32'h7CAAAAAA, 4'b1000, 4'b1010, 4'b1000));
        runVectors("f1k1");
        idle(3);

        F = 8'd0; K = 5'd7;
        idle(1);
        addVec(1'b1, 32'hBCBCBCBC, 4'b0100, mkRec(32'hFCBCFCBC, 4'b1110, 4'b1111, 4'b0000));
        addVec(1'b1, 32'hBCBCBCBC, 4'b0100, mkRec(32'h7CBCFCBC, 4'b1110, 4'b1111, 4'b1000));
        runVectors("k-char");
        idle(3);

        F = 8'd3; K = 5'd1; SCR = 1'b1;
        idle(1);
`ifdef JESD_TX_CHAR_REPLACE_SCR_EN
        addVec(1'b1, 32'hFC00FC00, 4'h0, mkRec(32'hFC00FC00, 4'b1000, 4'b1000, 4'b0000));
        addVec(1'b1, 32'h7C007C00, 4'h0, mkRec(32'h7C007C00, 4'b1000, 4'b1000, 4'b1000));
        addVec(1'b1, 32'h7C000000, 4'h0, mkRec(32'h7C000000, 4'b0000, 4'b1000, 4'b0000));
        addVec(1'b1, 32'hFC000000, 4'h0, mkRec(32'hFC000000, 4'b0000, 4'b1000, 4'b1000));
        runVectors("scrambled");
`else
        addVec(1'b1, 32'hFCFCFCFC, 4'h0, mkRec(32'hFCFCFCFC, 4'b0000, 4'b1000, 4'b0000));
        addVec(1'b1, 32'hFCFCFCFC, 4'h0, mkRec(32'h7CFCFCFC, 4'b1000, 4'b1000, 4'b1000));
        runVectors("scr ignored");
`endif
        SCR = 1'b0;
        idle(3);

        // A passed frame end before the gap must not leak into the first frame end after it.
        F = 8'd1; K = 5'd3;
        idle(2);
        applyStimulus(1'b1, 32'hAA333333, 4'h0, 1'b1);
        applyStimulus(1'b0, 32'hAAAAAAAA, 4'h0, 1'b1);
        checkRecord("pre-drop", mkRec(32'hAA333333, 4'b0000, 4'b1010, 4'b0000));
        applyStimulus(1'b0, 32'hAAAAAAAA, 4'h0, 1'b1);
        checkRecord("en low", mkRec(32'hAAAAAAAA, 4'b0000, 4'b0000, 4'b0000));
        applyStimulus(1'b0, 32'hAAAAAAAA, 4'h0, 1'b1);
        applyStimulus(1'b1, 32'hAAAAAAAA, 4'h0, 1'b1);
        applyStimulus(1'b1, 32'hAAAAAAAA, 4'h0, 1'b1);
        checkRecord("restart beat 0", mkRec(32'hFCAAAAAA, 4'b1000, 4'b1010, 4'b0000));
        applyStimulus(1'b1, 32'hAAAAAAAA, 4'h0, 1'b1);
        checkRecord("restart beat 1", mkRec(32'h7CAAAAAA, 4'b1000, 4'b1010, 4'b1000));
        idle(2);

        F = 8'd0; K = 5'd3;
        idle(1);
        repeat (3) applyStimulus(1'b1, 32'h55555555, 4'h0, 1'b1);
        applyStimulus(1'b0, 32'h55555555, 4'h0, 1'b0);
        checkRecord("mid reset", mkRec(32'h0, 4'h0, 4'h0, 4'h0));
        applyStimulus(1'b1, 32'h55555555, 4'h0, 1'b1);
        checkRecord("post reset flush", mkRec(32'h0, 4'h0, 4'h0, 4'h0));
        applyStimulus(1'b1, 32'h55555555, 4'h0, 1'b1);
        checkRecord("post reset beat 0", mkRec(32'h7C55FC55, 4'b1010, 4'b1111, 4'b1000));
        idle(2);

        for (int seg = 0; seg < 12; seg++) begin
            int fSel;
            int kSel;
            int len;
            do begin
                fSel = $urandom_range(0, 23);
                kSel = $urandom_range(0, 31);
            end while (((fSel + 1) * (kSel + 1)) % 4 != 0);
            F   = 8'(fSel);
            K   = 5'(kSel);
            SCR = 1'($urandom_range(0, 1));
            idle(2);
            len = $urandom_range(20, 60);
            for (int b = 0; b < len; b++) begin
                logic [31:0] d;
                logic [3:0]  dk;
                logic        en;
                for (int l = 0; l < 4; l++) begin
                    case ($urandom_range(0, 3))
                        0:       d[l*8 +: 8] = 8'h55;
                        1:       d[l*8 +: 8] = 8'hFC;
                        2:       d[l*8 +: 8] = 8'h7C;
                        default: d[l*8 +: 8] = 8'($urandom);
                    endcase
                    dk[l] = ($urandom_range(0, 15) == 0);
                end
                en = ($urandom_range(0, 24) != 0);
                applyStimulus(en, d, dk, 1'b1);
            end
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
